// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the CPU/loader memory arbiter.
package mem_arb_pkg;

    localparam int AWIDTH_DEF       = 5;
    localparam int DWIDTH_DEF       = 8;
    localparam int MAX_LD_BURST_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_LD   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-port memory bus; the arbiter is the master, the memory the slave.
interface mem_arbiter_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
);
    logic              mem_en;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter_mux.sv
// Combinational owner mux: routes the current owner onto the memory bus and
// derives the loader grant and CPU stall from the registered owner state.
module mem_arbiter_mux
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              rst,
    input  arb_state_t        state,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    input  logic              cpu_halted,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [AWIDTH-1:0] ld_addr,
    input  logic [DWIDTH-1:0] ld_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              ld_gnt,
    output logic              cpu_stall
);

    logic              en_src;
    logic              we_src;
    logic [AWIDTH-1:0] addr_src;
    logic [DWIDTH-1:0] wdata_src;

    always_comb begin
        en_src    = 1'b0;
        we_src    = 1'b0;
        addr_src  = '0;
        wdata_src = '0;
        case (state)
            ARB_CPU: begin
                en_src    = cpu_req;
                we_src    = cpu_we;
                addr_src  = cpu_addr;
                wdata_src = cpu_wdata;
            end
            ARB_LD: begin
                en_src    = ld_req;
                we_src    = ld_we;
                addr_src  = ld_addr;
                wdata_src = ld_wdata;
            end
            default: ;
        endcase
    end

    // Reset kills the strobe immediately so an in-flight write never lands.
    always_comb begin
        mem_en    = en_src & ~rst;
        mem_we    = we_src & mem_en;
        mem_addr  = mem_en ? addr_src : '0;
        mem_wdata = mem_we ? wdata_src : '0;
        ld_gnt    = (state == ARB_LD) & ld_req & ~rst;
        cpu_stall = cpu_req & ~cpu_halted & (state != ARB_CPU);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port memory between the CPU (locked per access) and
// the loader/debug port (burst-capped while the CPU waits).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH       = AWIDTH_DEF,
    parameter int DWIDTH       = DWIDTH_DEF,
    parameter int MAX_LD_BURST = MAX_LD_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    input  logic              cpu_halted,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [AWIDTH-1:0] ld_addr,
    input  logic [DWIDTH-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DWIDTH-1:0] ld_rdata,
    output logic              ld_rvalid,
    mem_arbiter_if.master     mem
);

    localparam int CW = (MAX_LD_BURST > 1) ? $clog2(MAX_LD_BURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LD_BURST - 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] ld_cnt_q, ld_cnt_d;
    logic          ld_rvalid_q, ld_rvalid_d;
    logic          cpu_want;

    mem_arbiter_mux #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_mux (
        .rst        (rst),
        .state      (state_q),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_halted (cpu_halted),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .mem_en     (mem.mem_en),
        .mem_we     (mem.mem_we),
        .mem_addr   (mem.mem_addr),
        .mem_wdata  (mem.mem_wdata),
        .ld_gnt     (ld_gnt),
        .cpu_stall  (cpu_stall)
    );

    always_comb begin
        cpu_want    = cpu_req & ~cpu_halted;
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        ld_rvalid_d = ld_gnt & ~ld_we;
        case (state_q)
            ARB_IDLE: begin
                if (cpu_want) begin
                    state_d = ARB_CPU;
                end else if (ld_req) begin
                    state_d  = ARB_LD;
                    ld_cnt_d = '0;
                end
            end
            ARB_CPU: begin
                if (!cpu_req) begin
                    if (ld_req) begin
                        state_d  = ARB_LD;
                        ld_cnt_d = '0;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            ARB_LD: begin
                // Counter saturates so a long solo burst still yields promptly once the CPU asks.
                if (!ld_req) begin
                    state_d = cpu_want ? ARB_CPU : ARB_IDLE;
                end else if (cpu_want && (ld_cnt_q == CNT_MAX)) begin
                    state_d  = ARB_CPU;
                    ld_cnt_d = '0;
                end else if (ld_cnt_q != CNT_MAX) begin
                    ld_cnt_d = ld_cnt_q + CW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            ld_cnt_q    <= '0;
            ld_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            ld_rvalid_q <= ld_rvalid_d;
        end
    end

    assign cpu_rdata = mem.mem_rdata;
    assign ld_rdata  = mem.mem_rdata;
    assign ld_rvalid = ld_rvalid_q;

endmodule
